// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display drivers: active-low digit
// patterns, the blank code and the bit positions inside the 8-bit segment bus.
package seg7_pkg;

  // Segment bus layout {p,a,b,c,d,e,f,g}.
  localparam int P_BIT = 7;
  localparam int A_BIT = 6;
  localparam int B_BIT = 5;
  localparam int C_BIT = 4;
  localparam int D_BIT = 3;
  localparam int E_BIT = 2;
  localparam int F_BIT = 1;
  localparam int G_BIT = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // {a..g} patterns for nibble values 0..F; a 0 lights the segment.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {a..g} decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit hex driver for a common-anode seven-segment bank.
// One digit is driven at a time; each is held SCAN_DIV cycles, and the first
// cycle of every window after the first has all anodes off to stop ghosting.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (never digit 0, and never a digit at or below a lit decimal point).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     le,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEGMENT
);

  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);
  localparam logic             GUARD_EN = (DIGITS > 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              guard_q, guard_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [3:0]        cur_nib;
  logic              cur_point;
  logic              cur_blank;
  logic [6:0]        cur_dec;
  logic [DIGITS-1:0] lz_supp;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Suppress digit i when it and every higher digit are zero with no point lit.
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_supp = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run & (hex[4*i +: 4] == 4'h0) & ~point[i];
      lz_supp[i] = run;
    end
  end
`else
  assign lz_supp = '0;
`endif

  // Select the nibble, point and blank flag of the digit currently scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_point = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        cur_nib   = hex[4*i +: 4];
        cur_point = point[i];
        cur_blank = le[i] | lz_supp[i];
      end
    end
  end

  hex_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_dec)
  );

  // Prescaler, digit advance, guard flag and next pin values.
  always_comb begin
    div_cnt_d = div_cnt_q;
    sel_d     = sel_q;
    guard_d   = guard_q;
    an_d      = '1;
    seg_d     = SEG_BLANK;
    if (en) begin
      if (!cur_blank) begin
        seg_d[P_BIT]       = ~cur_point;
        seg_d[A_BIT:G_BIT] = cur_dec;
      end
      if (!guard_q) begin
        for (int i = 0; i < DIGITS; i++) begin
          an_d[i] = (sel_q != SEL_W'(i));
        end
      end
      guard_d = 1'b0;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        guard_d   = GUARD_EN;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sel_q     <= '0;
      guard_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      div_cnt_q <= div_cnt_d;
      sel_q     <= sel_d;
      guard_q   <= guard_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN      = an_q;
  assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4) checked against
// a cycle-count reference model.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] hex = '0;
  logic [3:0]  point = '0;
  logic [3:0]  le = '0;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .hex     (hex),
    .point   (point),
    .le      (le),
    .AN      (AN),
    .SEGMENT (SEGMENT)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;  // enabled cycles since reset
  logic [3:0] exp_an;
  logic [7:0] exp_seg;

  logic [6:0] pat [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  // Apply one cycle of inputs, predict the pins, then check after the edge.
  task automatic cycle(input logic r, input logic e, input logic [15:0] h,
                       input logic [3:0] p, input logic [3:0] l);
    int   d;
    logic blank;
    logic zero;
    rst = r; en = e; hex = h; point = p; le = l;
    if (r) begin
      exp_an = 4'hF; exp_seg = 8'hFF; t = 0;
    end else if (!e) begin
      exp_an = 4'hF; exp_seg = 8'hFF;
    end else begin
      d      = (t / SCAN_DIV) % DIGITS;
      exp_an = (t >= SCAN_DIV && (t % SCAN_DIV) == 0) ? 4'hF : ~(4'b0001 << d);
      blank  = l[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d >= 1) begin
        zero = 1'b1;
        for (int j = d; j < DIGITS; j++)
          if (h[4*j +: 4] != 4'h0 || p[j]) zero = 1'b0;
        blank = blank | zero;
      end
`else
      zero = 1'b0;
      blank = blank | zero;
`endif
      exp_seg = blank ? 8'hFF : {~p[d], pat[h[4*d +: 4]]};
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("AN", 32'(AN), 32'(exp_an));
    chk("SEGMENT", 32'(SEGMENT), 32'(exp_seg));
  endtask

  initial begin
    logic [15:0] h;
    logic [15:0] m;
    @(negedge clk);
    cycle(1, 1, 16'h8A10, 4'h0, 4'h0);
    cycle(1, 0, 16'h8A10, 4'h0, 4'h0);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(SEGMENT), 32'hFF);

    cycle(0, 1, 16'h8A10, 4'h0, 4'h0);
    chk("first_an", 32'(AN), 32'hE);
    chk("first_seg", 32'(SEGMENT), 32'h81);
    repeat (3) cycle(0, 1, 16'h8A10, 4'h0, 4'h0);
    cycle(0, 1, 16'h8A10, 4'h0, 4'h0);
    chk("guard_an", 32'(AN), 32'hF);
    cycle(0, 1, 16'h8A10, 4'h0, 4'h0);
    chk("dig1_an", 32'(AN), 32'hD);
    chk("dig1_seg", 32'(SEGMENT), 32'hCF);
    repeat (16) cycle(0, 1, 16'h8A10, 4'h0, 4'h0);

    repeat (16) cycle(0, 1, 16'h8A10, 4'b1000, 4'h0);
    repeat (16) cycle(0, 1, 16'h8A10, 4'b1000, 4'b1000);

    // en dropped mid-window, then restored
    repeat (2) cycle(0, 1, 16'h1234, 4'h0, 4'h0);
    repeat (3) cycle(0, 0, 16'h1234, 4'h0, 4'h0);
    chk("en0_an", 32'(AN), 32'hF);
    repeat (10) cycle(0, 1, 16'h1234, 4'h0, 4'h0);

    // reset mid-frame, then restart from digit 0
    cycle(1, 1, 16'h1234, 4'h0, 4'h0);
    repeat (12) cycle(0, 1, 16'h1234, 4'h0, 4'h0);

    cycle(1, 1, 16'h0070, 4'h0, 4'h0);
    repeat (20) cycle(0, 1, 16'h0070, 4'h0, 4'h0);
    repeat (20) cycle(0, 1, 16'h0070, 4'b1000, 4'h0);

    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 4))
        0: m = 16'h000F;
        1: m = 16'h00FF;
        2: m = 16'h0FFF;
        default: m = 16'hFFFF;
      endcase
      h = 16'($urandom) & m;
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) != 0), h,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
